byte_packer: RTL

- Sits directly downstream of pad_strip and consumes its data_out stream.
- After pad insertion or strip, mid-packet beats can carry fewer than DATA_WIDTH/8 valid bytes. This block re-packs them into full-width beats.
- Only the final beat of a packet may be partial.
- Byte-stream valid/ready in and out; byte order is preserved.

---
 rtl/spcom_pkg.sv | 33 +++
 rtl/byte_merge.sv | 47 ++++
 rtl/byte_packer.sv | 111 +++++++++++
 3 files changed

// File: rtl/spcom_pkg.sv
// ----------------------------------------------------------------------------
// spcom_pkg: definitions shared by the streaming byte-path blocks (pad_strip,
// byte_packer).
//   - log2            : ceiling log2, usable in constant expressions.
//   - beat_bytes      : number of bytes carried by a beat of a given width.
//   - bcnt_width      : width of a byte-count field able to encode 0..bytes.
//   - STREAM_DATA_WIDTH : default beat width of the stream.
// ----------------------------------------------------------------------------
package spcom_pkg;

    localparam int STREAM_DATA_WIDTH = 128;

    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

    // A byte count must encode the full-beat value itself, hence the +1.
    function automatic int bcnt_width(input int data_width);
        return log2(data_width / 8) + 1;
    endfunction

endpackage

// File: rtl/byte_merge.sv
// ----------------------------------------------------------------------------
// byte_merge: combinational merge of one input beat into the packing
// accumulator.
//   acc      in   2*DATA_WIDTH  accumulator (already shifted for any output).
//   base     in   ACC_BCNT      byte offset at which the new bytes land.
//   data_in  in   DATA_WIDTH    input beat, byte 0 = bits [7:0].
//   bcnt     in   DATA_BCNT     valid bytes in data_in (already clamped).
//   en       in   1             merge enable (input handshake fired).
//   merged   out  2*DATA_WIDTH  accumulator with the new bytes ORed in.
// Bytes of data_in at index >= bcnt are zeroed so they cannot pollute the
// accumulator bytes above the fill count.
// ----------------------------------------------------------------------------
module byte_merge
    import spcom_pkg::*;
#(
    parameter int DATA_WIDTH = STREAM_DATA_WIDTH,
    parameter int DATA_BCNT  = bcnt_width(DATA_WIDTH),
    parameter int ACC_BCNT   = DATA_BCNT + 1
) (
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [ACC_BCNT-1:0]     base,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_BCNT-1:0]    bcnt,
    input  logic                    en,
    output logic [2*DATA_WIDTH-1:0] merged
);

    localparam int B = beat_bytes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]   masked;
    logic [2*DATA_WIDTH-1:0] shifted;

    always_comb begin
        masked = '0;
        for (int i = 0; i < B; i++) begin
            if (DATA_BCNT'(i) < bcnt) begin
                masked[i*8 +: 8] = data_in[i*8 +: 8];
            end
        end
    end

    // Byte-granular barrel shift: base bytes == base*8 bits.
    assign shifted = {{DATA_WIDTH{1'b0}}, masked} << {base, 3'b000};

    assign merged = en ? (acc | shifted) : acc;

endmodule

// File: rtl/byte_packer.sv
// ----------------------------------------------------------------------------
// byte_packer: re-packs a byte stream whose mid-packet beats may be partial
// into full-width beats; only the final beat of a packet can be partial.
//   clk            in   1           clock.
//   rst_n          in   1           asynchronous active-low reset.
//   data_in        in   DATA_WIDTH  input beat, byte 0 = bits [7:0].
//   data_in_bcnt   in   DATA_BCNT   valid bytes in data_in (values > B clamp).
//   data_in_eop    in   1           last beat of packet.
//   data_in_vld    in   1           input beat valid.
//   data_in_rdy    out  1           input beat accepted this cycle.
//   data_out       out  DATA_WIDTH  packed beat.
//   data_out_bcnt  out  DATA_BCNT   valid bytes in data_out.
//   data_out_eop   out  1           last beat of packet.
//   data_out_vld   out  1           output beat valid.
//   data_out_rdy   in   1           downstream accepts.
//
// Handshake: a beat moves only when vld & rdy are both high on a clock edge;
// while vld is high and rdy low the source holds data and qualifiers stable.
// data_out_rdy -> data_in_rdy is the only combinational path, giving full
// rate when the accumulator holds a full beat and downstream is taking it.
// ----------------------------------------------------------------------------
module byte_packer
    import spcom_pkg::*;
#(
    parameter int DATA_WIDTH = STREAM_DATA_WIDTH,
    parameter int DATA_BCNT  = bcnt_width(DATA_WIDTH),
    parameter int ACC_BCNT   = DATA_BCNT + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_BCNT-1:0]  data_in_bcnt,
    input  logic                  data_in_eop,
    input  logic                  data_in_vld,
    output logic                  data_in_rdy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_BCNT-1:0]  data_out_bcnt,
    output logic                  data_out_eop,
    output logic                  data_out_vld,
    input  logic                  data_out_rdy
);

    localparam int B = beat_bytes(DATA_WIDTH);
    localparam logic [ACC_BCNT-1:0]  B_ACC = ACC_BCNT'(B);
    localparam logic [DATA_BCNT-1:0] B_BC  = DATA_BCNT'(B);

    logic [2*DATA_WIDTH-1:0] acc, acc_shift, acc_next;
    logic [ACC_BCNT-1:0]     cnt, cnt_next, out_take, base;
    logic                    eop_pend, eop_pend_next;
    logic [DATA_BCNT-1:0]    bcnt_clamped, bcnt_add;
    logic                    in_fire, out_fire;

    // Outputs are decoded from registered state only.
    assign out_take      = (cnt >= B_ACC) ? B_ACC : cnt;
    assign data_out      = acc[DATA_WIDTH-1:0];
    assign data_out_vld  = (cnt >= B_ACC) | eop_pend;
    assign data_out_bcnt = (cnt >= B_ACC) ? B_BC : cnt[DATA_BCNT-1:0];
    assign data_out_eop  = eop_pend & (cnt <= B_ACC);

    // Input stalls while an eop is waiting, so packets never share a beat.
    assign data_in_rdy = !eop_pend & ((cnt < B_ACC) | data_out_rdy);

    assign in_fire  = data_in_vld & data_in_rdy;
    assign out_fire = data_out_vld & data_out_rdy;

    assign bcnt_clamped = (data_in_bcnt > B_BC) ? B_BC : data_in_bcnt;
    assign bcnt_add     = in_fire ? bcnt_clamped : '0;

    // Drain first, then merge: the new bytes land right after what remains.
    assign acc_shift = out_fire ? (acc >> {out_take, 3'b000}) : acc;
    assign base      = out_fire ? (cnt - out_take) : cnt;
    // base + bcnt never exceeds 2B-1, so cnt cannot overflow.
    assign cnt_next  = base + {{(ACC_BCNT-DATA_BCNT){1'b0}}, bcnt_add};

    byte_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_BCNT  (DATA_BCNT),
        .ACC_BCNT   (ACC_BCNT)
    ) u_merge (
        .acc     (acc_shift),
        .base    (base),
        .data_in (data_in),
        .bcnt    (bcnt_clamped),
        .en      (in_fire),
        .merged  (acc_next)
    );

    // Set and clear cannot coincide: in_fire needs !eop_pend, the clearing
    // out_fire needs eop_pend.
    always_comb begin
        eop_pend_next = eop_pend;
        if (in_fire && data_in_eop) begin
            eop_pend_next = 1'b1;
        end else if (out_fire && data_out_eop) begin
            eop_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            eop_pend <= 1'b0;
        end else begin
            acc      <= acc_next;
            cnt      <= cnt_next;
            eop_pend <= eop_pend_next;
        end
    end

endmodule
